// File: rtl/quat_interp_if.sv
// Handshake bundle between the timestamp aligner, the quaternion
// interpolation engine and the fusion filter input FIFO.
interface quat_interp_if #(
    parameter int W = 32
);
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic [4*W-1:0] q1;
    logic [4*W-1:0] q2;
    logic [W-1:0]   t;
    logic           out_valid;
    logic           out_ready;
    logic [4*W-1:0] q_out;
    logic           flipped;

    modport master (
        output in_valid, mode, q1, q2, t, out_ready,
        input  in_ready, out_valid, q_out, flipped
    );

    modport slave (
        input  in_valid, mode, q1, q2, t, out_ready,
        output in_ready, out_valid, q_out, flipped
    );
endinterface

// File: rtl/quat_interp_engine.sv
// Sequential quaternion interpolator: shortest-path blend
// (1-t)*q1 + t*q2' with optional single-step Newton-Raphson
// renormalisation. Components are {w,x,y,z}, w in the top W bits.
module quat_interp_engine #(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    quat_interp_if.slave  bus
);
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;
    localparam int AW = 2 * W + 2;

    localparam logic signed [W-1:0] ONE_C      = {{(W-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [W-1:0] ONE_HALF_C = {{(W-2){1'b0}}, 2'b11} << (FRAC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DOT  = 3'd1,
        S_WGT  = 3'd2,
        S_MIX  = 3'd3,
        S_NSQ  = 3'd4,
        S_NINV = 3'd5,
        S_NSCL = 3'd6,
        S_DONE = 3'd7
    } state_e;

    // Saturate a wide signed value to the W-bit range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] max_v;
        logic signed [AW-1:0] min_v;
        max_v = {{(AW-W){1'b0}}, 1'b0, {(W-1){1'b1}}};
        min_v = {{(AW-W){1'b1}}, 1'b1, {(W-1){1'b0}}};
        if (v > max_v) begin
            sat_w = max_v[W-1:0];
        end else if (v < min_v) begin
            sat_w = min_v[W-1:0];
        end else begin
            sat_w = v[W-1:0];
        end
    endfunction

    // Negate, mapping the most-negative value to the most-positive one.
    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        if (v == {1'b1, {(W-1){1'b0}}}) begin
            neg_sat = {1'b0, {(W-1){1'b1}}};
        end else begin
            neg_sat = -v;
        end
    endfunction

    // Full-precision signed product.
    function automatic logic signed [PW-1:0] mul_full(input logic signed [W-1:0] a,
                                                      input logic signed [W-1:0] b);
        mul_full = PW'(a) * PW'(b);
    endfunction

    state_e               state_r, state_nx_s;
    logic [1:0]           idx_r;
    logic                 mode_r;
    logic                 flipped_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic signed [W-1:0]  q1_r [4];
    logic signed [W-1:0]  q2_r [4];
    logic signed [W-1:0]  r_r  [4];
    logic signed [W-1:0]  t_r;
    logic signed [W-1:0]  w1_r;
    logic signed [W-1:0]  inv_r;
    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] n2_r;

    logic signed [W-1:0]  mul_a_s, mul_b_s, t_clamp_s;
    logic signed [PW-1:0] prod_s, blend_s;
    logic signed [SW-1:0] mix_sum_s;
    logic                 accept_s;

    assign accept_s  = bus.in_valid && in_ready_r;
    assign prod_s    = mul_full(mul_a_s, mul_b_s);
    assign blend_s   = mul_full(w1_r, q1_r[idx_r]);
    assign mix_sum_s = SW'(prod_s) + SW'(blend_s);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.flipped   = flipped_r;
    assign bus.q_out     = {r_r[0], r_r[1], r_r[2], r_r[3]};

    // Operand select for the shared multiplier.
    always_comb begin
        mul_a_s = {W{1'b0}};
        mul_b_s = {W{1'b0}};
        case (state_r)
            S_DOT: begin
                mul_a_s = q1_r[idx_r];
                mul_b_s = q2_r[idx_r];
            end
            S_MIX: begin
                mul_a_s = t_r;
                mul_b_s = q2_r[idx_r];
            end
            S_NSQ: begin
                mul_a_s = r_r[idx_r];
                mul_b_s = r_r[idx_r];
            end
            S_NSCL: begin
                mul_a_s = r_r[idx_r];
                mul_b_s = inv_r;
            end
            default: begin
                mul_a_s = {W{1'b0}};
                mul_b_s = {W{1'b0}};
            end
        endcase
    end

    // Clamp the interpolation parameter into [0, 1.0].
    always_comb begin
        t_clamp_s = t_r;
        if (t_r[W-1]) begin
            t_clamp_s = {W{1'b0}};
        end else if (t_r > ONE_C) begin
            t_clamp_s = ONE_C;
        end else begin
            t_clamp_s = t_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state sequencing; the four-step phases end when idx_r wraps.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nx_s = S_DOT;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_DOT: begin
                if (idx_r == 2'd3) begin
                    state_nx_s = S_WGT;
                end else begin
                    state_nx_s = S_DOT;
                end
            end
            S_WGT: state_nx_s = S_MIX;
            S_MIX: begin
                if (idx_r != 2'd3) begin
                    state_nx_s = S_MIX;
                end else if (mode_r) begin
                    state_nx_s = S_NSQ;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            S_NSQ: begin
                if (idx_r == 2'd3) begin
                    state_nx_s = S_NINV;
                end else begin
                    state_nx_s = S_NSQ;
                end
            end
            S_NINV: state_nx_s = S_NSCL;
            S_NSCL: begin
                if (idx_r == 2'd3) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_NSCL;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Handshake outputs, registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == S_IDLE);
            out_valid_r <= (state_nx_s == S_DONE);
        end
    end

    // Datapath: capture, dot product, weighting, blend and renormalise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                q1_r[i] <= {W{1'b0}};
                q2_r[i] <= {W{1'b0}};
                r_r[i]  <= {W{1'b0}};
            end
            idx_r     <= 2'd0;
            mode_r    <= 1'b0;
            flipped_r <= 1'b0;
            t_r       <= {W{1'b0}};
            w1_r      <= {W{1'b0}};
            inv_r     <= {W{1'b0}};
            acc_r     <= {AW{1'b0}};
            n2_r      <= {AW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < 4; i++) begin
                            q1_r[i] <= bus.q1[(3-i)*W +: W];
                            q2_r[i] <= bus.q2[(3-i)*W +: W];
                        end
                        t_r       <= bus.t;
                        mode_r    <= bus.mode;
                        flipped_r <= 1'b0;
                        idx_r     <= 2'd0;
                        acc_r     <= {AW{1'b0}};
                        n2_r      <= {AW{1'b0}};
                    end
                end
                S_DOT: begin
                    acc_r <= acc_r + AW'(prod_s);
                    idx_r <= idx_r + 2'd1;
                end
                S_WGT: begin
                    t_r  <= t_clamp_s;
                    w1_r <= ONE_C - t_clamp_s;
                    if (acc_r[AW-1]) begin
                        for (int i = 0; i < 4; i++) begin
                            q2_r[i] <= neg_sat(q2_r[i]);
                        end
                        flipped_r <= 1'b1;
                    end
                end
                S_MIX: begin
                    r_r[idx_r] <= sat_w(AW'(mix_sum_s) >>> FRAC);
                    idx_r      <= idx_r + 2'd1;
                end
                S_NSQ: begin
                    n2_r  <= n2_r + AW'(prod_s);
                    idx_r <= idx_r + 2'd1;
                end
                S_NINV: begin
                    inv_r <= sat_w(AW'(ONE_HALF_C) - (n2_r >>> (FRAC + 1)));
                end
                S_NSCL: begin
                    r_r[idx_r] <= sat_w(AW'(prod_s) >>> FRAC);
                    idx_r      <= idx_r + 2'd1;
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_quat_interp_engine.sv
// Directed scoreboard bench for quat_interp_engine (W=32, FRAC=16).
module tb_quat_interp_engine;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    quat_interp_if #(.W(32)) bus ();

    quat_interp_engine #(.W(32), .FRAC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [127:0] q;
        logic         flip;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [127:0] pk(input logic [31:0] w, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] z);
        return {w, x, y, z};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'd0);
        check({tag, "_q_out"}, bus.q_out, 128'd0);
        check({tag, "_flipped"}, 128'(bus.flipped), 128'd0);
    endtask

    // Drive one request and record its expected result.
    task automatic send(input logic [127:0] q1, input logic [127:0] q2, input logic [31:0] t,
                        input logic mode, input logic [127:0] exp_q, input logic exp_flip,
                        input int lat);
        exp_t e;
        e.q = exp_q;
        e.flip = exp_flip;
        e.lat = lat;
        sb_q.push_back(e);
        check("in_ready_before_accept", 128'(bus.in_ready), 128'd1);
        bus.q1 = q1;
        bus.q2 = q2;
        bus.t = t;
        bus.mode = mode;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.q1 = {$urandom, $urandom, $urandom, $urandom};
        bus.q2 = {$urandom, $urandom, $urandom, $urandom};
        bus.t = $urandom;
        bus.mode = 1'($urandom);
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall.
    task automatic collect(input int hold);
        exp_t e;
        int   n;
        logic [127:0] junk;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb_q.pop_front();
        check("latency", 128'(n), 128'(e.lat));
        check("q_out", bus.q_out, e.q);
        check("flipped", 128'(bus.flipped), 128'(e.flip));
        for (int k = 0; k < hold; k++) begin
            junk = {$urandom, $urandom, $urandom, $urandom};
            bus.q1 = junk;
            bus.mode = 1'b0;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_out_valid", 128'(bus.out_valid), 128'd1);
            check("hold_q_out", bus.q_out, e.q);
            check("hold_flipped", 128'(bus.flipped), 128'(e.flip));
            check("hold_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_out_valid", 128'(bus.out_valid), 128'd0);
        check("post_hs_in_ready", 128'(bus.in_ready), 128'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.mode = 1'b0;
        bus.q1 = 128'd0;
        bus.q2 = 128'd0;
        bus.t = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LERP basic
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'h0, 32'h0001_0000, 32'h0, 32'h0),
             32'h0000_8000, 1'b0, pk(32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0), 1'b0, 9);
        collect(0);

        // NLERP
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'h0, 32'h0001_0000, 32'h0, 32'h0),
             32'h0000_8000, 1'b1, pk(32'h0000_A000, 32'h0000_A000, 32'h0, 32'h0), 1'b0, 18);
        collect(0);

        // Shortest path flip
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'hFFFF_0000, 32'h0, 32'h0, 32'h0),
             32'h0000_8000, 1'b0, pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), 1'b1, 9);
        collect(0);

        // Clamp above 1.0 gives q2
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'h0, 32'h0001_0000, 32'h0, 32'h0),
             32'h0001_8000, 1'b0, pk(32'h0, 32'h0001_0000, 32'h0, 32'h0), 1'b0, 9);
        collect(0);

        // Clamp below 0 gives q1
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'h0, 32'h0001_0000, 32'h0, 32'h0),
             32'hFFFF_C000, 1'b0, pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), 1'b0, 9);
        collect(0);

        // Zero dot, negative component, floor shift
        send(pk(32'h0, 32'h0001_0000, 32'h0, 32'h0), pk(32'h0, 32'h0, 32'hFFFF_0000, 32'h0),
             32'h0000_4000, 1'b0, pk(32'h0, 32'h0000_C000, 32'hFFFF_C000, 32'h0), 1'b0, 9);
        collect(0);

        // Negating the most-negative component saturates
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'h8000_0000, 32'h0, 32'h0, 32'h0),
             32'h0001_0000, 1'b0, pk(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0), 1'b1, 9);
        collect(0);

        // Backpressure: 5 stalled cycles with a competing request
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'hFFFF_0000, 32'h0, 32'h0, 32'h0),
             32'h0000_8000, 1'b0, pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), 1'b1, 9);
        collect(5);
        repeat (20) @(posedge clk);
        #1;
        check("no_spurious_accept", 128'(bus.out_valid), 128'd0);

        // Reset in the middle of MIX
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'h0, 32'h0001_0000, 32'h0, 32'h0),
             32'h0000_8000, 1'b1, pk(32'h0000_A000, 32'h0000_A000, 32'h0, 32'h0), 1'b0, 18);
        void'(sb_q.pop_back());
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("aborted_no_out_valid", 128'(bus.out_valid), 128'd0);

        // Fresh request after the abort
        send(pk(32'h0001_0000, 32'h0, 32'h0, 32'h0), pk(32'h0, 32'h0001_0000, 32'h0, 32'h0),
             32'h0000_8000, 1'b1, pk(32'h0000_A000, 32'h0000_A000, 32'h0, 32'h0), 1'b0, 18);
        collect(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/quat_interp_engine.md
Name: quat_interp_engine

Overview:
- Parametrised, handshaked quaternion interpolator for the IMU synchroniser. It succeeds the fixed-width combinational SLERP datapath.
- Computes the shortest-path blend (1-t)*q1 + t*q2' using one shared multiplier. q2' is q2 sign-flipped when dot(q1,q2) < 0.
- Optionally renormalises the result with one Newton-Raphson inverse-sqrt step (NLERP mode).
- Sits between the timestamp aligner (sources q1/q2/t) and the fusion filter input FIFO.

Parameters:
- W, 32, data width of every quaternion component and t (signed two's complement).
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC); 1.0 = 1<<FRAC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  engine idle, request accepted on in_valid&&in_ready
- mode  in  1  0 = LERP (no normalise), 1 = NLERP (normalise); sampled at accept
- q1  in  4*W  first quaternion, packed {w,x,y,z}, w in [4W-1:3W]
- q2  in  4*W  second quaternion, same packing
- t  in  W  interpolation parameter, signed Q format
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result on out_valid&&out_ready
- q_out  out  4*W  interpolated quaternion, same packing
- flipped  out  1  1 when q2 was negated for shortest path

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, q_out=0, flipped=0, all internal regs 0.
- Input capture: q1, q2, t and mode are registered at accept. Inputs are don't-care afterwards.
- in_ready=1 only in IDLE. No accept while busy or while holding a result.
- FSM states and cycle counts:
  - IDLE: on accept, go to DOT.
  - DOT (4 cycles, one component per cycle): acc += q1[i]*q2[i].
  - WGT (1 cycle): clamp t to [0, 1.0] (t<0 gives 0, t>1.0 gives 1.0); w1 = 1.0 - t; if acc<0, negate q2 regs and set flipped.
  - MIX (4 cycles): r[i] = sat(w1*q1[i] + t*q2[i]). In LERP mode go to DONE; in NLERP mode go to NSQ.
  - NSQ (4 cycles): n2 += r[i]*r[i].
  - NINV (1 cycle): inv = sat(1.5 - n2/2), with 1.5 = 3<<(FRAC-1).
  - NSCL (4 cycles): r[i] = sat(r[i]*inv).
  - DONE: out_valid=1, q_out=r.
- Latency: out_valid rises exactly 9 cycles after the accept edge in LERP and 18 cycles after in NLERP.
- DONE holds q_out and flipped stable while out_valid && !out_ready. On handshake, out_valid drops next cycle and the FSM returns to IDLE (in_ready=1 that cycle).
- Arithmetic:
  - Each product is a full 2W-bit signed value.
  - Sums of two products are formed at 2W+1 bits before the shift.
  - Scaling is an arithmetic right shift by FRAC (floor), then saturation to W bits at [-(2^(W-1)), 2^(W-1)-1].
  - acc and n2 accumulate at 2W+2 bits in full precision and are shifted/saturated only when used.
- dot == 0 exactly: no flip.
- Negation of the most-negative value saturates to the max positive value.
- flipped is updated at WGT, cleared at accept, and valid with q_out.
- rst_n assertion mid-operation aborts immediately to the reset state. The partial result is discarded and no out_valid is produced.

Test Plan (FRAC=16, W=32):
- LERP basic: q1=(0x10000,0,0,0), q2=(0,0x10000,0,0), t=0x8000, mode=0 -> q_out=(0x8000,0x8000,0,0), flipped=0, out_valid 9 cycles after accept.
- NLERP: same stimulus, mode=1 -> n2=0x8000, inv=0x14000, q_out=(0xA000,0xA000,0,0), out_valid 18 cycles after accept.
- Shortest path: q1=(0x10000,0,0,0), q2=(-0x10000,0,0,0), t=0x8000, mode=0 -> flipped=1, q_out=(0x10000,0,0,0).
- Clamp: t=0x18000 -> q_out=q2 exactly. t=-0x4000 -> q_out=q1 exactly. flipped=0 in both.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> q_out/flipped stable, in_ready=0, a second in_valid is not accepted. Release -> out_valid low next cycle, in_ready high.
- Reset mid-op: assert rst_n=0 during MIX -> all outputs at reset values immediately. After release a new request completes with correct values.
